// File: rtl/avalon_7seg_ctrl.sv
// Avalon-MM slave driving eight active-low 7-segment displays.
// Holds per-digit nibble, blank, raw and raw-segment fields.
// Holds the enable/blink control, the blink half-period and the blink timer.
// Ports:
//   clk_clk, reset_reset_n       clock; synchronous active-low reset
//   avs_address/read/write/...   Avalon-MM slave, 1-cycle read latency
//   hex0..hex7                   registered segments, active-low, bit0=a
module avalon_7seg_ctrl #(
    parameter int          NUM_DIGITS    = 8,
    parameter logic [31:0] BLINK_DEFAULT = 32'd25000000,
    parameter logic [31:0] VERSION       = 32'h75E60001
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [3:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7
);

    logic [NUM_DIGITS-1:0][3:0] nib_q, nib_d;
    logic [NUM_DIGITS-1:0]      blank_q, blank_d;
    logic [NUM_DIGITS-1:0]      raw_q, raw_d;
    logic [NUM_DIGITS-1:0][6:0] rawseg_q, rawseg_d;
    logic                       enable_q, enable_d;
    logic                       blink_en_q, blink_en_d;
    logic [7:0]                 mask_q, mask_d;
    logic [31:0]                per_q, per_d;
    logic [31:0]                cnt_q, cnt_d;
    logic                       phase_q, phase_d;
    logic [31:0]                rdata_q, rdata_d;
    logic                       rvalid_q, rvalid_d;
    logic [NUM_DIGITS-1:0][6:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]      dark;
    logic [2:0]                 idx;
    logic                       per_wr;

    // Active-high gfedcba pattern for a hex nibble
    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    always_comb begin
        nib_d      = nib_q;
        blank_d    = blank_q;
        raw_d      = raw_q;
        rawseg_d   = rawseg_q;
        enable_d   = enable_q;
        blink_en_d = blink_en_q;
        mask_d     = mask_q;
        per_d      = per_q;
        rdata_d    = rdata_q;
        rvalid_d   = avs_read;
        idx        = avs_address[2:0];
        per_wr     = avs_write && (avs_address == 4'd9);

        if (avs_write) begin
            if (!avs_address[3]) begin
                nib_d[idx]    = avs_writedata[3:0];
                blank_d[idx]  = avs_writedata[4];
                raw_d[idx]    = avs_writedata[5];
                rawseg_d[idx] = avs_writedata[14:8];
            end else begin
                case (idx)
                    3'd0: begin
                        enable_d   = avs_writedata[0];
                        blink_en_d = avs_writedata[1];
                        mask_d     = avs_writedata[15:8];
                    end
                    // A zero period would never let the counter wrap
                    3'd1: per_d = (avs_writedata == 32'd0) ? 32'd1
                                                           : avs_writedata;
                    3'd2: begin
                        nib_d   = avs_writedata;
                        blank_d = '0;
                        raw_d   = '0;
                    end
                    default: ;
                endcase
            end
        end

        // Reads see the pre-write register contents
        if (avs_read) begin
            if (!avs_address[3]) begin
                rdata_d = {17'd0, rawseg_q[idx], 2'b00,
                           raw_q[idx], blank_q[idx], nib_q[idx]};
            end else begin
                case (idx)
                    3'd0:    rdata_d = {16'd0, mask_q, 6'd0,
                                        blink_en_q, enable_q};
                    3'd1:    rdata_d = per_q;
                    3'd2:    rdata_d = nib_q;
                    3'd3:    rdata_d = VERSION;
                    default: rdata_d = 32'd0;
                endcase
            end
        end

        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!blink_en_q) begin
            cnt_d   = 32'd0;
            phase_d = 1'b0;
        end else if (per_wr) begin
            cnt_d = 32'd0;
        end else if (cnt_q >= per_q - 32'd1) begin
            cnt_d   = 32'd0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            dark[i] = !enable_q || blank_q[i] ||
                      (blink_en_q && mask_q[i] && phase_q);
            hex_d[i] = dark[i] ? 7'h7F
                     : ~(raw_q[i] ? rawseg_q[i] : hex_decode(nib_q[i]));
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            nib_q      <= '0;
            blank_q    <= '0;
            raw_q      <= '0;
            rawseg_q   <= '0;
            enable_q   <= 1'b1;
            blink_en_q <= 1'b0;
            mask_q     <= 8'd0;
            per_q      <= BLINK_DEFAULT;
            cnt_q      <= 32'd0;
            phase_q    <= 1'b0;
            rdata_q    <= 32'd0;
            rvalid_q   <= 1'b0;
            hex_q      <= {NUM_DIGITS{7'h7F}};
        end else begin
            nib_q      <= nib_d;
            blank_q    <= blank_d;
            raw_q      <= raw_d;
            rawseg_q   <= rawseg_d;
            enable_q   <= enable_d;
            blink_en_q <= blink_en_d;
            mask_q     <= mask_d;
            per_q      <= per_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            hex_q      <= hex_d;
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign hex6 = hex_q[6];
    assign hex7 = hex_q[7];

endmodule

// File: tb/tb_avalon_7seg_ctrl.sv
// Directed self-checking bench for avalon_7seg_ctrl.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_avalon_7seg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic [6:0]  h0, h1, h2, h3, h4, h5, h6, h7;
    logic [6:0]  hx [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_7seg_ctrl dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .avs_address      (addr),
        .avs_read         (rd_en),
        .avs_write        (wr_en),
        .avs_writedata    (wdata),
        .avs_readdata     (rdata),
        .avs_readdatavalid(rvalid),
        .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3),
        .hex4(h4), .hex5(h5), .hex6(h6), .hex7(h7)
    );

    assign hx[0] = h0;
    assign hx[1] = h1;
    assign hx[2] = h2;
    assign hx[3] = h3;
    assign hx[4] = h4;
    assign hx[5] = h5;
    assign hx[6] = h6;
    assign hx[7] = h7;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d,
                      output logic v);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata;
        v = rvalid;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic v;
        rst_n = 1'b0;
        idle(3);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (hx[i] !== 7'h7F) begin
                errors++;
                $display("FAIL rst_hex%0d: got %h expected 7f", i, hx[i]);
            end
        end
        checks++;
        if (rvalid !== 1'b0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_rd: got v=%b d=%h expected v=0 d=0",
                     rvalid, rdata);
        end
        rst_n = 1'b1;
        idle(2);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (hx[i] !== 7'h40) begin
                errors++;
                $display("FAIL idle_hex%0d: got %h expected 40", i, hx[i]);
            end
        end
        rd(4'd8, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'h1) begin
            errors++;
            $display("FAIL rd_ctrl: got v=%b d=%h expected v=1 d=1", v, d);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_pulse: got %b expected 0", rvalid);
        end
    endtask

    task automatic test_packed;
        logic [31:0] d;
        logic v;
        wr(4'd10, 32'h89ABCDEF);
        checks++;
        if (h0 !== 7'h40) begin
            errors++;
            $display("FAIL packed_lat: got %h expected 40", h0);
        end
        @(negedge clk);
        checks++;
        if (h0 !== 7'h0E || h1 !== 7'h06 || h2 !== 7'h21 || h7 !== 7'h00) begin
            errors++;
            $display("FAIL packed_hex: got %h %h %h %h expected 0e 06 21 00",
                     h0, h1, h2, h7);
        end
        rd(4'd10, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'h89ABCDEF) begin
            errors++;
            $display("FAIL rd_packed: got %h expected 89abcdef", d);
        end
        rd(4'd11, d, v);
        checks++;
        if (d !== 32'h75E60001) begin
            errors++;
            $display("FAIL rd_id: got %h expected 75e60001", d);
        end
    endtask

    task automatic test_raw_blank;
        logic [31:0] d;
        logic v;
        wr(4'd3, 32'h0000_4920);
        @(negedge clk);
        checks++;
        if (h3 !== 7'h36) begin
            errors++;
            $display("FAIL raw_hex3: got %h expected 36", h3);
        end
        rd(4'd3, d, v);
        checks++;
        if (d !== 32'h4920) begin
            errors++;
            $display("FAIL rd_digit3: got %h expected 00004920", d);
        end
        wr(4'd3, 32'h0000_4930);
        @(negedge clk);
        checks++;
        if (h3 !== 7'h7F) begin
            errors++;
            $display("FAIL blank_hex3: got %h expected 7f", h3);
        end
    endtask

    task automatic test_blink;
        logic [6:0] exp;
        wr(4'd9, 32'd4);
        wr(4'd8, 32'h0000_0103);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp = ((((k - 1) / 4) % 2) == 1) ? 7'h7F : 7'h0E;
            checks++;
            if (h0 !== exp || h1 !== 7'h06) begin
                errors++;
                $display("FAIL blink_c%0d: got h0=%h h1=%h expected %h 06",
                         k, h0, h1, exp);
            end
        end
        wr(4'd8, 32'h0000_0101);
        idle(2);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (h0 !== 7'h0E) begin
                errors++;
                $display("FAIL blink_off_c%0d: got %h expected 0e", k, h0);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic v;
        wr(4'd2, 32'h5);
        @(negedge clk);
        addr = 4'd2; wdata = 32'hA; rd_en = 1'b1; wr_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h5) begin
            errors++;
            $display("FAIL rw_same: got v=%b d=%h expected v=1 d=5",
                     rvalid, rdata);
        end
        @(negedge clk);
        checks++;
        if (h2 !== 7'h08) begin
            errors++;
            $display("FAIL rw_hex2: got %h expected 08", h2);
        end
        wr(4'd13, 32'hFFFF_FFFF);
        rd(4'd13, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL rd_rsvd: got %h expected 0", d);
        end
        wr(4'd11, 32'h1234_5678);
        rd(4'd11, d, v);
        checks++;
        if (d !== 32'h75E60001) begin
            errors++;
            $display("FAIL id_ro: got %h expected 75e60001", d);
        end
        wr(4'd9, 32'd0);
        rd(4'd9, d, v);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL per_zero: got %h expected 1", d);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic v;
        wr(4'd9, 32'd4);
        wr(4'd8, 32'h0000_0103);
        idle(6);
        @(negedge clk);
        addr = 4'd9; rd_en = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        rd_en = 1'b0; rst_n = 1'b1;
        checks++;
        if (rvalid !== 1'b0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL mid_rst_rd: got v=%b d=%h expected v=0 d=0",
                     rvalid, rdata);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (hx[i] !== 7'h7F) begin
                errors++;
                $display("FAIL mid_rst_hex%0d: got %h expected 7f", i, hx[i]);
            end
        end
        rd(4'd8, d, v);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL mid_ctrl: got %h expected 1", d);
        end
        rd(4'd9, d, v);
        checks++;
        if (d !== 32'd25000000) begin
            errors++;
            $display("FAIL mid_per: got %0d expected 25000000", d);
        end
        rd(4'd10, d, v);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL mid_packed: got %h expected 0", d);
        end
        rd(4'd3, d, v);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL mid_digit3: got %h expected 0", d);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (hx[i] !== 7'h40) begin
                errors++;
                $display("FAIL mid_hex%0d: got %h expected 40", i, hx[i]);
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_packed();
        test_raw_blank();
        test_blink();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
